// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: steers a serial TDM bit stream into three per-channel deserialisers with word-valid strobes.
module tdm_demux_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [1:0]       sel,
  input  logic             enable,
  input  logic             flush,
  input  logic             clr_err,
  output logic [WIDTH-1:0] word_a,
  output logic [WIDTH-1:0] word_b,
  output logic [WIDTH-1:0] word_c,
  output logic             valid_a,
  output logic             valid_b,
  output logic             valid_c,
  output logic             err_sel
);
  localparam int CW = $clog2(WIDTH);
  logic [2:0][WIDTH-1:0] words;
  logic [2:0]            valids;
  logic                  err_q, err_d;
  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic [WIDTH-1:0] sr_q, sr_d, word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, acc, done;
    always_comb begin
      acc     = enable && !flush && (sel == 2'(k));
      done    = acc && (cnt_q == CW'(WIDTH - 1));
      sr_d    = flush ? '0 : acc ? {sr_q[WIDTH-2:0], din} : sr_q;
      cnt_d   = (flush || done) ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
      word_d  = done ? {sr_q[WIDTH-2:0], din} : word_q;
      valid_d = done;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q    <= '0;
        cnt_q   <= '0;
        word_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        sr_q    <= sr_d;
        cnt_q   <= cnt_d;
        word_q  <= word_d;
        valid_q <= valid_d;
      end
    end
    assign words[k]  = word_q;
    assign valids[k] = valid_q;
  end
  // an illegal tag in the same cycle as a clear keeps the flag set
  assign err_d = (enable && sel == 2'd3) || (err_q && !clr_err);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign word_a  = words[0];
  assign word_b  = words[1];
  assign word_c  = words[2];
  assign valid_a = valids[0];
  assign valid_b = valids[1];
  assign valid_c = valids[2];
  assign err_sel = err_q;
endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of the time-multiplexed single-bit link driven by the registered 3:1 selector: one data bit per clock plus a channel select and an enable.
- Steers each enabled bit to one of three channels (a, b, c) and deserialises it into that channel's shift register.
- Publishes a complete WIDTH-bit word per channel with a one-cycle valid strobe.
- Sits between the link and the per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- din  input  1  serial data bit from the link
- sel  input  2  channel tag for din: 0=a, 1=b, 2=c, 3=illegal
- enable  input  1  din/sel valid this cycle
- flush  input  1  synchronous discard of all partial words
- clr_err  input  1  synchronous clear of err_sel
- word_a  output  WIDTH  last completed word, channel a
- word_b  output  WIDTH  last completed word, channel b
- word_c  output  WIDTH  last completed word, channel c
- valid_a  output  1  one-cycle strobe: word_a updated
- valid_b  output  1  one-cycle strobe: word_b updated
- valid_c  output  1  one-cycle strobe: word_c updated
- err_sel  output  1  sticky flag: enable seen with sel==3

Behaviour:
- Reset (rst=1, asynchronous) clears everything to 0 immediately: shift registers, bit counters, word_*, valid_*, err_sel.
- Reset released mid-word: the partial word is lost; the next accepted bit for that channel is bit 0 of a new word.
- Per channel, independent state:
  - shift register sr[WIDTH-1:0];
  - bit counter cnt, range 0..WIDTH-1, width $clog2(WIDTH).
- Accept condition: enable=1, flush=0, sel==k (k in 0..2).
- On accept for channel k:
  - sr_k <= {sr_k[WIDTH-2:0], din}; MSB is sent first.
  - If cnt_k == WIDTH-1: word_k <= {sr_k[WIDTH-2:0], din}, valid_k <= 1 next cycle, cnt_k <= 0 (wrap).
  - Otherwise cnt_k <= cnt_k + 1.
- Latency: valid_k and the new word_k appear on the clock edge that samples the WIDTH-th bit; they are visible in the following cycle.
- valid_k is high for exactly one cycle per completed word.
- Back-to-back words on one channel give a valid_k pulse every WIDTH accepted cycles; there are no gaps in acceptance.
- Non-selected channels hold sr and cnt. Interleaving channels arbitrarily (e.g. a,b,a,c,...) is legal; each channel assembles only its own bits.
- enable=0: no state change except that valid_* deassert.
- sel==3 with enable=1:
  - bit discarded; no channel state changes;
  - err_sel <= 1 (sticky).
- clr_err=1: err_sel <= 0, unless an illegal sel is accepted in the same cycle; set wins, so err_sel stays 1.
- flush=1:
  - all cnt <= 0 and all sr <= 0; the current din is discarded even if enable=1;
  - a word that would have completed this cycle does not complete, and valid stays 0;
  - word_* hold their last completed values;
  - err_sel is unaffected, and flush does not block an err_sel set from sel==3.
- word_k holds its value until the next completion on channel k. There is no consumer backpressure: a new word overwrites the old one.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle -> all outputs 0 at once; hold enable=0 for 20 cycles -> outputs stay 0, no valid.
- Single word: WIDTH=8, sel=0, enable=1, send bits of 0xA5 MSB-first over 8 cycles -> valid_a=1 for exactly one cycle after the 8th bit, word_a=0xA5, valid_b=valid_c=0.
- Interleave: alternate sel 0,1,2 each cycle, feeding a=0x3C, b=0xC3, c=0xFF bit-serially -> after 24 cycles valid_a, valid_b, valid_c each pulse once on consecutive cycles; words 0x3C/0xC3/0xFF.
- Back-to-back plus enable gaps: 0x12 then 0x34 on channel b with enable dropped for 3 cycles mid-word -> two valid_b pulses, word_b=0x12 then 0x34, no corruption.
- Flush: 5 bits of channel c, then flush=1 with enable=1, then a full 0x81 -> one valid_c only, word_c=0x81; the prior word_c value is retained through the flush.
- Error: enable=1, sel=3 -> err_sel=1 next cycle, no valid; clr_err=1 together with another sel=3 -> err_sel stays 1; clr_err alone -> err_sel=0.
